// File: rtl/id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl
//
// ID-stage hazard and stall controller for a 5-stage MIPS pipeline.
// A small FSM (RUN / STALL / FREEZE) with a down-counter generates multi-cycle
// load-to-use stalls. A data-memory ready handshake freezes the whole
// pipeline while a multi-cycle memory access is outstanding. All outputs are
// combinational from state, counter and inputs, so a hazard stalls in the same
// cycle it is detected.
//
// Parameters:
//   REG_AW   register address width
//   LOAD_LAT cycles after MEM before load data is forwardable (1..3)
//   CNT_W    stall counter width, must hold LOAD_LAT+1
//
// Ports:
//   CLK, RESET        clock (rising edge), asynchronous active-low reset
//   ID_*              decoded fields of the instruction sitting in ID
//   Branch_Taken      branch compare result computed in ID
//   EX_*, MEM_*       write-back info of the instructions in EX and MEM
//   Mem_Ready         data memory ready; low freezes the pipeline
//   PCWrite/IFIDWrite PC and IF/ID write enables
//   IF_Flush          zero IF/ID on the next edge (taken branch / jump)
//   Hazard_Ctrl       inject zero control word (bubble) into ID/EX
//   PipeFreeze        hold ID/EX, EX/MEM and MEM/WB
//   Stall_Cause       00 none, 01 data stall, 10 memory freeze, 11 flush
//
// Optional feature (macro HAZ_PERF_CNT_EN): adds saturating 32-bit counters
// Perf_Stall, Perf_Freeze and Perf_Flush counting cycles with Stall_Cause
// 01, 10 and 11. Without the macro these ports and counters do not exist.
// ---------------------------------------------------------------------------
module id_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ID_Valid,
    input  logic [REG_AW-1:0] ID_RS,
    input  logic [REG_AW-1:0] ID_RT,
    input  logic              ID_UsesRS,
    input  logic              ID_UsesRT,
    input  logic              ID_IsBranch,
    input  logic              ID_IsJump,
    input  logic              ID_IsJR,
    input  logic              Branch_Taken,
    input  logic              EX_RegWrite,
    input  logic              EX_MemRead,
    input  logic [REG_AW-1:0] EX_RD,
    input  logic              MEM_RegWrite,
    input  logic              MEM_MemRead,
    input  logic [REG_AW-1:0] MEM_RD,
    input  logic              Mem_Ready,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              IF_Flush,
    output logic              Hazard_Ctrl,
    output logic              PipeFreeze,
    output logic [1:0]        Stall_Cause
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       Perf_Stall,
    output logic [31:0]       Perf_Freeze,
    output logic [31:0]       Perf_Flush
`endif
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_STALL  = 2'd1,
        S_FREEZE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] N_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] N_LAT  = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] N_LAT1 = CNT_W'(LOAD_LAT + 1);

    state_t           r_state;
    state_t           r_ret_state;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_eff_state;
    logic             w_ne;
    logic             w_ex_match;
    logic             w_mem_match;
    logic [CNT_W-1:0] w_n;
    logic             w_freeze;
    logic             w_stall;
    logic             w_flush;

    // A load in MEM always writes its register and ALU results in MEM are
    // forwarded, so MEM_RegWrite carries no extra information here.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, MEM_RegWrite};

    // Branches and jr consume their operands in ID, so they need results
    // earlier than ordinary instructions that get forwarded into EX.
    assign w_ne = ID_IsBranch | ID_IsJR;

    // Register 0 is hard-wired to zero and never creates a dependency.
    assign w_ex_match  = (EX_RD != '0) &
                         ((ID_UsesRS & (ID_RS == EX_RD)) |
                          (ID_UsesRT & (ID_RT == EX_RD)));
    assign w_mem_match = (MEM_RD != '0) &
                         ((ID_UsesRS & (ID_RS == MEM_RD)) |
                          (ID_UsesRT & (ID_RT == MEM_RD)));

    // Required stall length: maximum over all applicable producer terms.
    always_comb begin
        w_n = '0;
        if (EX_MemRead && w_ex_match)
            w_n = w_ne ? N_LAT1 : N_LAT;
        if (w_ne && EX_RegWrite && !EX_MemRead && w_ex_match && (N_ONE > w_n))
            w_n = N_ONE;
        if (w_ne && MEM_MemRead && w_mem_match && (N_LAT > w_n))
            w_n = N_LAT;
        if (!ID_Valid)
            w_n = '0;
    end

    // On the release cycle of a freeze the controller behaves exactly as the
    // saved state would, so the saved state stands in for FREEZE.
    assign w_eff_state = (r_state == S_FREEZE) ? r_ret_state : r_state;

    assign w_freeze = ~Mem_Ready;
    assign w_stall  = ~w_freeze &
                      (((w_eff_state == S_RUN) & (w_n != '0)) |
                       (w_eff_state == S_STALL));
    assign w_flush  = ~w_freeze & ~w_stall & (w_eff_state == S_RUN) &
                      ID_Valid & (ID_IsJump | (ID_IsBranch & Branch_Taken));

    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IF_Flush    = 1'b0;
        Hazard_Ctrl = 1'b0;
        PipeFreeze  = 1'b0;
        Stall_Cause = 2'b00;
        if (!RESET) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            Hazard_Ctrl = 1'b1;
        end else if (w_freeze) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            PipeFreeze  = 1'b1;
            Stall_Cause = 2'b10;
        end else if (w_stall) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            Hazard_Ctrl = 1'b1;
            Stall_Cause = 2'b01;
        end else if (w_flush) begin
            IF_Flush    = 1'b1;
            Stall_Cause = 2'b11;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_RUN;
            r_ret_state <= S_RUN;
            r_cnt       <= '0;
        end else if (w_freeze) begin
            // Counter is held; remember where to resume.
            r_state     <= S_FREEZE;
            r_ret_state <= w_eff_state;
        end else begin
            case (w_eff_state)
                S_STALL: begin
                    // The cycle that takes cnt to zero is the last stall cycle.
                    if (r_cnt <= N_ONE) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_STALL;
                        r_cnt   <= r_cnt - N_ONE;
                    end
                end
                default: begin
                    // One stall cycle is spent in RUN itself; only the rest
                    // needs the STALL state.
                    if (w_n > N_ONE) begin
                        r_state <= S_STALL;
                        r_cnt   <= w_n - N_ONE;
                    end else begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_freeze;
    logic [31:0] r_perf_flush;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_perf_stall  <= '0;
            r_perf_freeze <= '0;
            r_perf_flush  <= '0;
        end else begin
            if (Stall_Cause == 2'b01) r_perf_stall  <= sat_inc(r_perf_stall);
            if (Stall_Cause == 2'b10) r_perf_freeze <= sat_inc(r_perf_freeze);
            if (Stall_Cause == 2'b11) r_perf_flush  <= sat_inc(r_perf_flush);
        end
    end

    assign Perf_Stall  = r_perf_stall;
    assign Perf_Freeze = r_perf_freeze;
    assign Perf_Flush  = r_perf_flush;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl (default parameters, LOAD_LAT = 1).
// Inputs are driven on the falling edge; the expected output word is queued
// at that moment and popped/compared 2 time units later, well before the
// next rising edge. Output word = {PCWrite, IFIDWrite, IF_Flush, Hazard_Ctrl,
// PipeFreeze, Stall_Cause}.
module tb_id_hazard_ctrl;
    localparam int REG_AW = 5;

    localparam logic [6:0] E_NORM  = 7'b1100000;
    localparam logic [6:0] E_STALL = 7'b0001001;
    localparam logic [6:0] E_FRZ   = 7'b0000110;
    localparam logic [6:0] E_FLUSH = 7'b1110011;
    localparam logic [6:0] E_RST   = 7'b0001000;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              ID_Valid, ID_UsesRS, ID_UsesRT, ID_IsBranch, ID_IsJump, ID_IsJR;
    logic              Branch_Taken, EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead, Mem_Ready;
    logic [REG_AW-1:0] ID_RS, ID_RT, EX_RD, MEM_RD;
    logic              PCWrite, IFIDWrite, IF_Flush, Hazard_Ctrl, PipeFreeze;
    logic [1:0]        Stall_Cause;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]       Perf_Stall, Perf_Freeze, Perf_Flush;
`endif

    logic [6:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    id_hazard_ctrl #(.REG_AW(REG_AW), .LOAD_LAT(1), .CNT_W(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .ID_Valid(ID_Valid), .ID_RS(ID_RS), .ID_RT(ID_RT),
        .ID_UsesRS(ID_UsesRS), .ID_UsesRT(ID_UsesRT),
        .ID_IsBranch(ID_IsBranch), .ID_IsJump(ID_IsJump), .ID_IsJR(ID_IsJR),
        .Branch_Taken(Branch_Taken),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_RD(EX_RD),
        .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_RD(MEM_RD),
        .Mem_Ready(Mem_Ready),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IF_Flush(IF_Flush),
        .Hazard_Ctrl(Hazard_Ctrl), .PipeFreeze(PipeFreeze), .Stall_Cause(Stall_Cause)
`ifdef HAZ_PERF_CNT_EN
        ,
        .Perf_Stall(Perf_Stall), .Perf_Freeze(Perf_Freeze), .Perf_Flush(Perf_Flush)
`endif
    );

    function automatic logic [6:0] outs();
        return {PCWrite, IFIDWrite, IF_Flush, Hazard_Ctrl, PipeFreeze, Stall_Cause};
    endfunction

    task automatic clr_inputs();
        ID_Valid = 0; ID_RS = '0; ID_RT = '0; ID_UsesRS = 0; ID_UsesRT = 0;
        ID_IsBranch = 0; ID_IsJump = 0; ID_IsJR = 0; Branch_Taken = 0;
        EX_RegWrite = 0; EX_MemRead = 0; EX_RD = '0;
        MEM_RegWrite = 0; MEM_MemRead = 0; MEM_RD = '0;
        Mem_Ready = 1;
    endtask

    task automatic ex_load(input logic [REG_AW-1:0] rd);
        EX_MemRead = 1; EX_RegWrite = 1; EX_RD = rd;
    endtask

    task automatic id_beq_rt(input logic [REG_AW-1:0] rt, input logic taken);
        ID_Valid = 1; ID_IsBranch = 1; ID_UsesRS = 1; ID_RS = 5'd1;
        ID_UsesRT = 1; ID_RT = rt; Branch_Taken = taken;
    endtask

    task automatic test_reset();
        logic [6:0] got, ex;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            clr_inputs();
            case (c)
                0: begin RESET = 0; exp_q.push_back(E_RST); end
                1: begin RESET = 0; ex_load(5'd8); ID_Valid = 1; ID_RS = 5'd8; ID_UsesRS = 1;
                         exp_q.push_back(E_RST); end
                default: begin RESET = 1; exp_q.push_back(E_NORM); end
            endcase
            #2;
            got = outs(); ex = exp_q.pop_front(); n_total++;
            if (got !== ex) $display("FAIL reset c=%0d got=%b exp=%b", c, got, ex);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        logic [6:0] got, ex;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            clr_inputs();
            case (c)
                0: begin ex_load(5'd8); ID_Valid = 1; ID_RS = 5'd8; ID_UsesRS = 1;
                         exp_q.push_back(E_STALL); end
                1: begin MEM_MemRead = 1; MEM_RegWrite = 1; MEM_RD = 5'd8;
                         ID_Valid = 1; ID_RS = 5'd8; ID_UsesRS = 1; exp_q.push_back(E_NORM); end
                2: begin ex_load(5'd8); ID_Valid = 1; ID_RS = 5'd8; ID_UsesRS = 0;
                         ID_RT = 5'd3; ID_UsesRT = 1; exp_q.push_back(E_NORM); end
                3: begin ex_load(5'd12); ID_Valid = 1; ID_RT = 5'd12; ID_UsesRT = 1;
                         exp_q.push_back(E_STALL); end
                default: exp_q.push_back(E_NORM);
            endcase
            #2;
            got = outs(); ex = exp_q.pop_front(); n_total++;
            if (got !== ex) $display("FAIL load_use c=%0d got=%b exp=%b", c, got, ex);
            else n_pass++;
        end
    endtask

    task automatic test_branch_load();
        logic [6:0] got, ex;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            clr_inputs();
            case (c)
                0: begin ex_load(5'd10); id_beq_rt(5'd10, 1'b1); exp_q.push_back(E_STALL); end
                1: begin MEM_MemRead = 1; MEM_RegWrite = 1; MEM_RD = 5'd10;
                         id_beq_rt(5'd10, 1'b1); exp_q.push_back(E_STALL); end
                2: begin MEM_MemRead = 1; MEM_RegWrite = 1; MEM_RD = 5'd10;
                         id_beq_rt(5'd10, 1'b1); exp_q.push_back(E_STALL); end
                3: begin id_beq_rt(5'd10, 1'b1); exp_q.push_back(E_FLUSH); end
                default: exp_q.push_back(E_NORM);
            endcase
            #2;
            got = outs(); ex = exp_q.pop_front(); n_total++;
            if (got !== ex) $display("FAIL branch_load c=%0d got=%b exp=%b", c, got, ex);
            else n_pass++;
        end
    endtask

    task automatic test_alu_branch();
        logic [6:0] got, ex;
        for (int c = 0; c < 7; c++) begin
            @(negedge CLK);
            clr_inputs();
            case (c)
                0: begin EX_RegWrite = 1; EX_RD = 5'd9; ID_Valid = 1; ID_IsBranch = 1;
                         ID_RS = 5'd9; ID_UsesRS = 1; exp_q.push_back(E_STALL); end
                1: begin MEM_RegWrite = 1; MEM_RD = 5'd9; ID_Valid = 1; ID_IsBranch = 1;
                         ID_RS = 5'd9; ID_UsesRS = 1; exp_q.push_back(E_NORM); end
                2: begin EX_RegWrite = 1; EX_RD = 5'd0; ID_Valid = 1; ID_IsBranch = 1;
                         ID_RS = 5'd0; ID_UsesRS = 1; exp_q.push_back(E_NORM); end
                3: begin EX_RegWrite = 1; EX_RD = 5'd9; ID_Valid = 1;
                         ID_RS = 5'd9; ID_UsesRS = 1; exp_q.push_back(E_NORM); end
                4: begin EX_RegWrite = 1; EX_RD = 5'd9; ID_Valid = 1; ID_IsJump = 1; ID_IsJR = 1;
                         ID_RS = 5'd9; ID_UsesRS = 1; exp_q.push_back(E_STALL); end
                5: begin ID_Valid = 1; ID_IsJump = 1; ID_IsJR = 1;
                         ID_RS = 5'd9; ID_UsesRS = 1; exp_q.push_back(E_FLUSH); end
                default: begin ex_load(5'd9); ID_Valid = 0; ID_IsJump = 1;
                         ID_RS = 5'd9; ID_UsesRS = 1; exp_q.push_back(E_NORM); end
            endcase
            #2;
            got = outs(); ex = exp_q.pop_front(); n_total++;
            if (got !== ex) $display("FAIL alu_branch c=%0d got=%b exp=%b", c, got, ex);
            else n_pass++;
        end
    endtask

    task automatic test_freeze_stall();
        logic [6:0] got, ex;
        for (int c = 0; c < 9; c++) begin
            @(negedge CLK);
            clr_inputs();
            case (c)
                0: begin ex_load(5'd10); id_beq_rt(5'd10, 1'b0); exp_q.push_back(E_STALL); end
                1, 2, 3: begin Mem_Ready = 0; id_beq_rt(5'd10, 1'b0); exp_q.push_back(E_FRZ); end
                4: begin id_beq_rt(5'd10, 1'b0); exp_q.push_back(E_STALL); end
                5: begin id_beq_rt(5'd10, 1'b0); exp_q.push_back(E_NORM); end
                6: begin Mem_Ready = 0; ex_load(5'd8); ID_Valid = 1; ID_RS = 5'd8; ID_UsesRS = 1;
                         exp_q.push_back(E_FRZ); end
                7: begin ex_load(5'd8); ID_Valid = 1; ID_RS = 5'd8; ID_UsesRS = 1;
                         exp_q.push_back(E_STALL); end
                default: exp_q.push_back(E_NORM);
            endcase
            #2;
            got = outs(); ex = exp_q.pop_front(); n_total++;
            if (got !== ex) $display("FAIL freeze_stall c=%0d got=%b exp=%b", c, got, ex);
            else n_pass++;
        end
    endtask

    task automatic test_jump_freeze();
        logic [6:0] got, ex;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            clr_inputs();
            case (c)
                0, 1: begin Mem_Ready = 0; ID_Valid = 1; ID_IsJump = 1; exp_q.push_back(E_FRZ); end
                2: begin ID_Valid = 1; ID_IsJump = 1; exp_q.push_back(E_FLUSH); end
                default: exp_q.push_back(E_NORM);
            endcase
            #2;
            got = outs(); ex = exp_q.pop_front(); n_total++;
            if (got !== ex) $display("FAIL jump_freeze c=%0d got=%b exp=%b", c, got, ex);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [6:0] got, ex;
        for (int c = 0; c < 7; c++) begin
            @(negedge CLK);
            clr_inputs();
            case (c)
                0: begin ex_load(5'd10); id_beq_rt(5'd10, 1'b0); exp_q.push_back(E_STALL); end
                1: begin RESET = 0; id_beq_rt(5'd10, 1'b0); exp_q.push_back(E_RST); end
                2, 3, 6: begin RESET = 1; exp_q.push_back(E_NORM); end
                4: begin Mem_Ready = 0; exp_q.push_back(E_FRZ); end
                default: begin RESET = 0; Mem_Ready = 0; exp_q.push_back(E_RST); end
            endcase
            #2;
            got = outs(); ex = exp_q.pop_front(); n_total++;
            if (got !== ex) $display("FAIL reset_mid c=%0d got=%b exp=%b", c, got, ex);
            else n_pass++;
`ifdef HAZ_PERF_CNT_EN
            if (c == 1) begin
                n_total++;
                if ({Perf_Stall, Perf_Freeze, Perf_Flush} !== 96'd0)
                    $display("FAIL perf_clear got=%0d/%0d/%0d exp=0/0/0",
                             Perf_Stall, Perf_Freeze, Perf_Flush);
                else n_pass++;
            end
`endif
        end
    endtask

    initial begin
        clr_inputs();
        RESET = 0;
        test_reset();
        test_load_use();
        test_branch_load();
        test_alu_branch();
        test_freeze_stall();
        test_jump_freeze();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
